// File: rtl/bitop_arbiter.sv
// bitop_arbiter: round-robin arbiter for two requesters sharing one
// 16-bit bitwise logic unit, with a registered, tagged response.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   reqN_valid/ready    request handshake, N = 0,1
//   reqN_a, reqN_b      16-bit operands
//   reqN_op             00 AND, 01 OR, 10 XOR, 11 ANDN (A & ~B)
//   rsp_valid/ready     response handshake
//   rsp_id              requester that issued the response
//   rsp_data, rsp_zero  result and (result == 0) flag
//   op_count            wrapping count of accepted requests
module bitop_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic [15:0] op_count
);

  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [15:0] r_rsp_data;
  logic        r_rsp_zero;
  logic        r_last_gnt;
  logic [15:0] r_op_count;

  logic        w_slot_free;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_accept;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [1:0]  w_op;
  logic [15:0] w_result;

  // The output slot is free if empty or being drained this cycle.
  assign w_slot_free = !r_rsp_valid || rsp_ready;

  // Under contention, the requester not served last wins.
  assign w_gnt0 = req0_valid &&
                  (!req1_valid || r_last_gnt);
  assign w_gnt1 = req1_valid &&
                  (!req0_valid || !r_last_gnt);

  assign req0_ready = w_gnt0 && w_slot_free;
  assign req1_ready = w_gnt1 && w_slot_free;
  assign w_accept   = req0_ready || req1_ready;

  always_comb begin
    w_a      = req0_a;
    w_b      = req0_b;
    w_op     = req0_op;
    w_result = 16'h0000;
    if (w_gnt1) begin
      w_a  = req1_a;
      w_b  = req1_b;
      w_op = req1_op;
    end
    unique case (w_op)
      2'b00: w_result = w_a & w_b;
      2'b01: w_result = w_a | w_b;
      2'b10: w_result = w_a ^ w_b;
      2'b11: w_result = w_a & ~w_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_zero  <= 1'b1;
      r_last_gnt  <= 1'b1;
      r_op_count  <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_gnt1;
        r_rsp_data  <= w_result;
        r_rsp_zero  <= (w_result == 16'h0000);
        r_last_gnt  <= w_gnt1;
        r_op_count  <= r_op_count + 16'd1;
      end else if (rsp_ready) begin
        // Data is kept; only the valid bit drops.
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_bitop_arbiter.sv
// tb_bitop_arbiter: vector table, directed corner sequences and
// randomized traffic against a reference model of bitop_arbiter.
module tb_bitop_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [15:0] req0_a = '0;
  logic [15:0] req0_b = '0;
  logic [1:0]  req0_op = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [15:0] req1_a = '0;
  logic [15:0] req1_b = '0;
  logic [1:0]  req1_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  bitop_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [1:0]  op0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        v1;
    logic [1:0]  op1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        rdy;
    logic        e_r0;
    logic        e_r1;
    logic        e_val;
    logic        e_id;
    logic [15:0] e_data;
    logic        e_zero;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [9];

  // Reference model state
  logic        m_valid;
  logic        m_id;
  logic [15:0] m_data;
  logic        m_last;
  int          m_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      case (op)
        2'd0: r[i] = a[i] && b[i];
        2'd1: r[i] = a[i] || b[i];
        2'd2: r[i] = a[i] != b[i];
        default: r[i] = a[i] && !b[i];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic v0, input logic [1:0] op0,
                       input logic [15:0] a0, input logic [15:0] b0,
                       input logic v1, input logic [1:0] op1,
                       input logic [15:0] a1, input logic [15:0] b1,
                       input logic rdy);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0; m_id = 1'b0; m_data = 16'h0;
    m_last = 1'b1; m_cnt = 0;
  endtask

  task automatic rnd_step();
    int g;
    logic [15:0] r;
    drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
          16'($urandom), 16'($urandom),
          $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
          16'($urandom), 16'($urandom),
          $urandom_range(0, 3) != 0);
    g = -1;
    if (req0_valid && req1_valid) g = m_last ? 0 : 1;
    else if (req0_valid) g = 0;
    else if (req1_valid) g = 1;
    if (m_valid && !rsp_ready) g = -1;
    @(negedge clk);
    chk("rnd_ready0", req0_ready, g == 0);
    chk("rnd_ready1", req1_ready, g == 1);
    if (g == 0) r = ref_op(req0_op, req0_a, req0_b);
    else        r = ref_op(req1_op, req1_a, req1_b);
    if (g >= 0) begin
      m_valid = 1'b1; m_id = (g == 1); m_data = r;
      m_last = (g == 1); m_cnt = (m_cnt + 1) % 65536;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("rnd_valid", rsp_valid, m_valid);
    chk("rnd_id", rsp_id, m_id);
    chk("rnd_data", rsp_data, m_data);
    chk("rnd_zero", rsp_zero, m_data == 16'h0);
    chk("rnd_count", op_count, m_cnt);
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd0, 16'hF0F0, 16'hFF00, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hF000, 1'b0, 16'd1};
    tbl[1] = '{1'b1, 2'd1, 16'hF0F0, 16'hFF00, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFF0, 1'b0, 16'd2};
    tbl[2] = '{1'b1, 2'd2, 16'hF0F0, 16'hFF00, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0FF0, 1'b0, 16'd3};
    tbl[3] = '{1'b1, 2'd3, 16'hF0F0, 16'hFF00, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00F0, 1'b0, 16'd4};
    tbl[4] = '{1'b1, 2'd0, 16'h5555, 16'hAAAA, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd5};
    tbl[5] = '{1'b1, 2'd3, 16'h5555, 16'hAAAA, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 16'd6};
    tbl[6] = '{1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd2, 16'h1234, 16'h00FF,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h12CB, 1'b0, 16'd7};
    tbl[7] = '{1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h12CB, 1'b0, 16'd7};
    tbl[8] = '{1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h12CB, 1'b0, 16'd7};

    do_reset();
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_zero", rsp_zero, 1'b1);
    chk("rst_count", op_count, 16'h0);

    // Vector table
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
            tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].e_r0);
      chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].e_r1);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), rsp_valid, tbl[i].e_val);
      chk($sformatf("tbl%0d_id", i), rsp_id, tbl[i].e_id);
      chk($sformatf("tbl%0d_data", i), rsp_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_zero", i), rsp_zero, tbl[i].e_zero);
      chk($sformatf("tbl%0d_count", i), op_count, tbl[i].e_cnt);
    end

    // Asynchronous reset with a response pending
    drive(1'b1, 2'd0, 16'hF0F0, 16'hFF00, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_valid", rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", rsp_valid, 1'b0);
    chk("async_id", rsp_id, 1'b0);
    chk("async_data", rsp_data, 16'h0);
    chk("async_zero", rsp_zero, 1'b1);
    chk("async_count", op_count, 16'h0);
    drive(1'b1, 2'd1, 16'h1111, 16'h0F0F, 1'b1, 2'd2, 16'hFFFF, 16'h00FF,
          1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_count", op_count, 16'h0);

    // Contention: first grant goes to requester 0, then alternates
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("cont%0d_ready0", i), req0_ready, (i % 2) == 0);
      chk($sformatf("cont%0d_ready1", i), req1_ready, (i % 2) == 1);
      @(posedge clk); #1;
      chk($sformatf("cont%0d_id", i), rsp_id, (i % 2) == 1);
      chk($sformatf("cont%0d_data", i), rsp_data,
          (i % 2) ? 16'hFF00 : 16'h1F1F);
    end
    chk("cont_count", op_count, 16'd6);

    // Backpressure: pending result from requester 1 must hold
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready0", i), req0_ready, 1'b0);
      chk($sformatf("bp%0d_ready1", i), req1_ready, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), rsp_valid, 1'b1);
      chk($sformatf("bp%0d_id", i), rsp_id, 1'b1);
      chk($sformatf("bp%0d_data", i), rsp_data, 16'hFF00);
    end
    chk("bp_count", op_count, 16'd6);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ready0", req0_ready, 1'b1);
    chk("bp_rel_ready1", req1_ready, 1'b0);
    @(posedge clk); #1;
    chk("bp_rel_valid", rsp_valid, 1'b1);
    chk("bp_rel_id", rsp_id, 1'b0);
    chk("bp_rel_data", rsp_data, 16'h1F1F);
    chk("bp_rel_count", op_count, 16'd7);

    // Randomized traffic against the reference model
    do_reset();
    repeat (3000) rnd_step();

    // Counter wrap
    do_reset();
    drive(1'b1, 2'd0, 16'h1, 16'h1, 1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", op_count, 16'hFFFF);
    @(posedge clk); #1;
    chk("wrap_zero", op_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitop_arbiter.md
# bitop_arbiter

Two-requester arbiter and sequencer for the shared 16-bit bitwise logic unit in the datapath. It accepts bitwise-operation requests (AND/OR/XOR/ANDN) from two independent requesters (e.g. execute stage and a debug/test port), grants one per cycle by round-robin, and computes the result in the shared unit. It returns the result through a single registered response stage tagged with the requester ID. It also keeps a wrapping count of completed operations.

## Interface
- No parameters; data width fixed at 16.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle when high with req0_valid
- req0_a, req0_b  in  16 each  operands, requester 0
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 ANDN (A & ~B)
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes response when high with rsp_valid
- rsp_id  out  1  requester that issued the response
- rsp_data  out  16  result
- rsp_zero  out  1  high when rsp_data == 16'h0000
- op_count  out  16  number of accepted requests, wraps 16'hFFFF -> 16'h0000

## Operation
- State: response register {rsp_valid, rsp_id, rsp_data, rsp_zero}, round-robin pointer last_gnt (1 bit), op_count.
- Reset (rst_n low, async): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=1, last_gnt=1, op_count=0. Any pending response is discarded.
- slot_free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Only one valid request: that requester.
  - Both valid: the requester != last_gnt.
  - None valid: no grant.
- reqN_ready = grant==N && slot_free. At most one ready is high per cycle. Ready never asserts for a non-valid requester.
- Accept = reqN_valid && reqN_ready. On accept:
  - The response register loads the result of the granted requester's op on its a and b operands.
  - rsp_id=N and rsp_valid=1.
  - last_gnt=N and op_count increments.
- No accept && rsp_ready && rsp_valid: rsp_valid clears and data holds its last value.
- No accept && !rsp_ready: the register holds unchanged. last_gnt is unchanged whenever no accept occurs.
- Simultaneous consume and accept: the new result replaces the old one in the same edge with no bubble.
- Requesters must hold a, b and op stable while valid && !ready. The block samples them only at accept.

## Timing
- Latency: accepted at edge T, so rsp_valid/rsp_data are valid after edge T and visible in cycle T+1.
- Throughput: 1 result/cycle while rsp_ready is held high. Both requesters continuously valid alternate 0,1,0,1...
- Backpressure: with rsp_valid=1 and rsp_ready=0, both readies are low. The block stalls with no loss and no duplication.
- Fairness: a continuously valid requester waits at most 1 accepted grant of the other requester.
- Combinational paths:
  - reqN_valid -> req(1-N)_ready
  - rsp_ready -> reqN_ready
  - No path from any input to rsp_* or op_count.
- op_count wraps silently. No overflow flag.

## Test plan
- Reset then idle:
  - Stimulus: assert rst_n low mid-stream while rsp_valid=1.
  - Required: outputs go to the reset values immediately, without waiting for a clock edge. After release, op_count=0, and the first contended cycle grants requester 0.
- All four ops on requester 0 alone, a=16'hF0F0, b=16'hFF00, rsp_ready=1:
  - rsp_data sequence 16'hF000, 16'hFFF0, 16'h0FF0, 16'h00F0.
  - rsp_id=0 for each result.
  - Each result appears one cycle after its accept.
- Contention, both valid every cycle, rsp_ready=1:
  - Grants alternate 0,1,0,1, with one accept per cycle.
  - After 6 cycles op_count=6.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles with a response pending and both requesters valid.
  - Required during the stall: both readies stay low, and rsp_data and rsp_id are stable.
  - Required after rsp_ready rises: the pending result is consumed and a new accept occurs in the same cycle.
- Zero flag:
  - a=16'h5555, b=16'hAAAA, op AND gives rsp_data=0 and rsp_zero=1.
  - The same operands with op ANDN give 16'h5555 and rsp_zero=0.
- Counter wrap:
  - Issue 65536 accepts; op_count returns to 16'h0000.
  - Verify the value 16'hFFFF on the preceding cycle.
